// File: rtl/nvme_pcie_pkg.sv
// Shared PCIe request/completion definitions for the BAR completer:
// request-type and completion-status codes, FSM encoding, descriptor field offsets.
package nvme_pcie_pkg;

    localparam logic [3:0] REQ_MEM_RD = 4'b0000;
    localparam logic [3:0] REQ_MEM_WR = 4'b0001;

    localparam logic [2:0] CPL_STATUS_SC = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_DATA  = 2'd1,
        ST_CPL      = 2'd2,
        ST_CPL_WAIT = 2'd3
    } bar_state_t;

    // CQ descriptor field offsets (low bit of each field)
    localparam int CQ_ADDR_LO = 2;
    localparam int CQ_DW_LO   = 64;
    localparam int CQ_TYPE_LO = 75;
    localparam int CQ_RID_LO  = 80;
    localparam int CQ_TAG_LO  = 96;
    localparam int CQ_TC_LO   = 121;
    localparam int CQ_ATTR_LO = 124;

    // CC descriptor field offsets (low bit of each field)
    localparam int CC_LADDR_LO = 0;
    localparam int CC_BC_LO    = 16;
    localparam int CC_DW_LO    = 32;
    localparam int CC_STAT_LO  = 43;
    localparam int CC_RID_LO   = 48;
    localparam int CC_TAG_LO   = 64;
    localparam int CC_TC_LO    = 89;
    localparam int CC_ATTR_LO  = 92;
    localparam int CC_DATA_LO  = 96;

    typedef struct packed {
        logic [9:0]  dw_addr;   // addr[11:2]
        logic [10:0] dw_cnt;
        logic [3:0]  req_type;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [2:0]  tc;
        logic [2:0]  attr;
        logic [3:0]  first_be;
    } cq_hdr_t;

    function automatic cq_hdr_t decode_cq(input logic [127:0] d, input logic [3:0] be);
        cq_hdr_t h;
        h.dw_addr  = d[CQ_ADDR_LO +: 10];
        h.dw_cnt   = d[CQ_DW_LO +: 11];
        h.req_type = d[CQ_TYPE_LO +: 4];
        h.rid      = d[CQ_RID_LO +: 16];
        h.tag      = d[CQ_TAG_LO +: 8];
        h.tc       = d[CQ_TC_LO +: 3];
        h.attr     = d[CQ_ATTR_LO +: 3];
        h.first_be = be;
        return h;
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int unsigned b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // Everything except MemWr and the message types expects a completion.
    function automatic logic is_non_posted(input logic [3:0] t);
        return !(t == REQ_MEM_WR || t == 4'b1100 || t == 4'b1101 || t == 4'b1110);
    endfunction

endpackage

// File: rtl/bar_reg_file.sv
// 32-bit register file: byte-enable write, registered read, and a registered
// copy of the post-merge write value for the write-notify strobe.
module bar_reg_file
    import nvme_pcie_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    output logic [31:0]      merged_data
);

    logic [31:0] regs [REG_COUNT];
    logic [31:0] wr_merged;

    // Merge incoming bytes over the current register contents
    always_comb begin
        wr_merged = be_merge(regs[wr_idx], wr_data, wr_be);
    end

    // Register update, registered read port and merged-value capture
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            rd_data     <= '0;
            merged_data <= '0;
        end else begin
            if (wr_en) begin
                regs[wr_idx] <= wr_merged;
                merged_data  <= wr_merged;
            end
            rd_data <= regs[rd_idx];
        end
    end

endmodule

// File: rtl/bar_completer.sv
// BAR completer: single-dword MemRd/MemWr target for a small register file,
// driven from an AXIS CQ stream and answering on an AXIS CC stream.
// Optional BAR_COMPLETER_UR_EN: unsupported non-posted requests get a UR completion.
module bar_completer
    import nvme_pcie_pkg::*;
#(
    parameter int C_DATA_WIDTH        = 128,
    parameter int AXI4_CQ_TUSER_WIDTH = 88,
    parameter int AXI4_CC_TUSER_WIDTH = 33,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int REG_COUNT           = 16
) (
    input  logic                           user_clk,
    input  logic                           user_reset,
    input  logic                           user_lnk_up,
    input  logic [C_DATA_WIDTH-1:0]        m_axis_cq_tdata,
    input  logic [AXI4_CQ_TUSER_WIDTH-1:0] m_axis_cq_tuser,
    input  logic [KEEP_WIDTH-1:0]          m_axis_cq_tkeep,
    input  logic                           m_axis_cq_tlast,
    input  logic                           m_axis_cq_tvalid,
    output logic                           m_axis_cq_tready,
    output logic [C_DATA_WIDTH-1:0]        s_axis_cc_tdata,
    output logic [AXI4_CC_TUSER_WIDTH-1:0] s_axis_cc_tuser,
    output logic [KEEP_WIDTH-1:0]          s_axis_cc_tkeep,
    output logic                           s_axis_cc_tlast,
    output logic                           s_axis_cc_tvalid,
    input  logic [3:0]                     s_axis_cc_tready,
    output logic                           reg_wr_valid,
    output logic [5:0]                     reg_wr_idx,
    output logic [31:0]                    reg_wr_data,
    output logic [15:0]                    req_cnt
);

    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    bar_state_t state, state_nxt;
    cq_hdr_t    hdr, in_hdr;
    logic       rst, cc_rdy, cc_load;
    logic       in_range, in_rd_ok, in_wr_ok, in_needs_cpl;
    logic       desc_fire, data_fire, reg_we;
    logic       cpl_pend, hdr_ur, wr_pend;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_data;
    logic [127:0]     cc_beat;
    logic [KEEP_WIDTH-1:0] cc_keep;
    logic       unused_bits;

    assign rst    = user_reset | ~user_lnk_up;
    assign cc_rdy = |s_axis_cc_tready;
    assign in_hdr = decode_cq(m_axis_cq_tdata[127:0], m_axis_cq_tuser[3:0]);

    assign in_range = ({22'd0, in_hdr.dw_addr} < 32'(REG_COUNT));
    assign in_rd_ok = (in_hdr.req_type == REQ_MEM_RD) && (in_hdr.dw_cnt == 11'd1) && in_range;
    assign in_wr_ok = (in_hdr.req_type == REQ_MEM_WR) && (in_hdr.dw_cnt == 11'd1) && in_range;
`ifdef BAR_COMPLETER_UR_EN
    assign in_needs_cpl = in_rd_ok || is_non_posted(in_hdr.req_type);
`else
    assign in_needs_cpl = in_rd_ok;
`endif

    assign desc_fire = (state == ST_IDLE) && m_axis_cq_tvalid;
    assign data_fire = (state == ST_WR_DATA) && m_axis_cq_tvalid;
    assign reg_we    = data_fire && wr_pend;

    // Read address comes straight off the descriptor beat so the data is
    // ready by the time the FSM sits in ST_CPL.
    assign rd_idx = (state == ST_IDLE) ? in_hdr.dw_addr[IDX_W-1:0] : hdr.dw_addr[IDX_W-1:0];

    assign s_axis_cc_tuser = '0;
    assign unused_bits = ^{m_axis_cq_tdata, m_axis_cq_tuser, m_axis_cq_tkeep,
                           hdr.dw_addr, hdr.dw_cnt, hdr.req_type};

    bar_reg_file #(
        .REG_COUNT (REG_COUNT),
        .IDX_W     (IDX_W)
    ) u_reg_file (
        .clk         (user_clk),
        .rst         (rst),
        .wr_en       (reg_we),
        .wr_idx      (hdr.dw_addr[IDX_W-1:0]),
        .wr_be       (hdr.first_be),
        .wr_data     (m_axis_cq_tdata[31:0]),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .merged_data (reg_wr_data)
    );

    // FSM state register
    always_ff @(posedge user_clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state and CQ ready
    // A beat still pending from an earlier completion (ready dropped after
    // ST_CPL exited to idle) stalls ST_CPL rather than being overwritten.
    always_comb begin
        state_nxt        = state;
        m_axis_cq_tready = 1'b0;
        cc_load          = 1'b0;
        case (state)
            ST_IDLE: begin
                m_axis_cq_tready = 1'b1;
                if (m_axis_cq_tvalid) begin
                    if (!m_axis_cq_tlast)  state_nxt = ST_WR_DATA;
                    else if (in_needs_cpl) state_nxt = ST_CPL;
                end
            end
            ST_WR_DATA: begin
                m_axis_cq_tready = 1'b1;
                if (m_axis_cq_tvalid && m_axis_cq_tlast)
                    state_nxt = cpl_pend ? ST_CPL : ST_IDLE;
            end
            ST_CPL: begin
                if (!(s_axis_cc_tvalid && !cc_rdy)) begin
                    cc_load   = 1'b1;
                    state_nxt = cc_rdy ? ST_IDLE : ST_CPL_WAIT;
                end
            end
            ST_CPL_WAIT: begin
                if (cc_rdy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Header capture and pending-action flags
    always_ff @(posedge user_clk) begin
        if (rst) begin
            hdr      <= '0;
            cpl_pend <= 1'b0;
            hdr_ur   <= 1'b0;
            wr_pend  <= 1'b0;
        end else if (desc_fire) begin
            hdr      <= in_hdr;
            cpl_pend <= in_needs_cpl;
            hdr_ur   <= !in_rd_ok;
            wr_pend  <= in_wr_ok && !m_axis_cq_tlast;
        end else if (data_fire) begin
            wr_pend  <= 1'b0;
        end
    end

    // Accepted-descriptor counter
    always_ff @(posedge user_clk) begin
        if (rst)            req_cnt <= '0;
        else if (desc_fire) req_cnt <= req_cnt + 16'd1;
    end

    // Completion beat contents
    always_comb begin
        cc_beat = '0;
        cc_beat[CC_LADDR_LO +: 7] = {hdr.dw_addr[4:0], 2'b00};
        cc_beat[CC_RID_LO +: 16]  = hdr.rid;
        cc_beat[CC_TAG_LO +: 8]   = hdr.tag;
        cc_beat[CC_TC_LO +: 3]    = hdr.tc;
        cc_beat[CC_ATTR_LO +: 3]  = hdr.attr;
        if (hdr_ur) begin
            cc_beat[CC_STAT_LO +: 3] = CPL_STATUS_UR;
            cc_keep = KEEP_WIDTH'(4'b0111);
        end else begin
            cc_beat[CC_STAT_LO +: 3] = CPL_STATUS_SC;
            cc_beat[CC_BC_LO +: 13]  = 13'd4;
            cc_beat[CC_DW_LO +: 11]  = 11'd1;
            cc_beat[CC_DATA_LO +: 32] = rd_data;
            cc_keep = KEEP_WIDTH'(4'b1111);
        end
    end

    // CC output register: load in ST_CPL, hold until accepted
    always_ff @(posedge user_clk) begin
        if (rst) begin
            s_axis_cc_tdata  <= '0;
            s_axis_cc_tkeep  <= '0;
            s_axis_cc_tlast  <= 1'b0;
            s_axis_cc_tvalid <= 1'b0;
        end else if (cc_load) begin
            s_axis_cc_tdata  <= C_DATA_WIDTH'(cc_beat);
            s_axis_cc_tkeep  <= cc_keep;
            s_axis_cc_tlast  <= 1'b1;
            s_axis_cc_tvalid <= 1'b1;
        end else if (s_axis_cc_tvalid && cc_rdy) begin
            s_axis_cc_tvalid <= 1'b0;
        end
    end

    // Write-notify strobe, aligned with the register update
    always_ff @(posedge user_clk) begin
        if (rst) begin
            reg_wr_valid <= 1'b0;
            reg_wr_idx   <= '0;
        end else begin
            reg_wr_valid <= reg_we;
            if (reg_we) reg_wr_idx <= 6'(hdr.dw_addr[IDX_W-1:0]);
        end
    end

endmodule

// File: tb/tb_bar_completer.sv
// Directed self-checking bench for bar_completer (default parameters).
// Build with BAR_COMPLETER_UR_EN to check the UR completion variant.
module tb_bar_completer;

    logic         clk = 1'b0;
    logic         user_reset, user_lnk_up;
    logic [127:0] cq_tdata;
    logic [87:0]  cq_tuser;
    logic [3:0]   cq_tkeep;
    logic         cq_tlast, cq_tvalid, cq_tready;
    logic [127:0] cc_tdata;
    logic [32:0]  cc_tuser;
    logic [3:0]   cc_tkeep;
    logic         cc_tlast, cc_tvalid;
    logic [3:0]   cc_tready;
    logic         reg_wr_valid;
    logic [5:0]   reg_wr_idx;
    logic [31:0]  reg_wr_data;
    logic [15:0]  req_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bar_completer #(
        .C_DATA_WIDTH        (128),
        .AXI4_CQ_TUSER_WIDTH (88),
        .AXI4_CC_TUSER_WIDTH (33),
        .KEEP_WIDTH          (4),
        .REG_COUNT           (16)
    ) dut (
        .user_clk         (clk),
        .user_reset       (user_reset),
        .user_lnk_up      (user_lnk_up),
        .m_axis_cq_tdata  (cq_tdata),
        .m_axis_cq_tuser  (cq_tuser),
        .m_axis_cq_tkeep  (cq_tkeep),
        .m_axis_cq_tlast  (cq_tlast),
        .m_axis_cq_tvalid (cq_tvalid),
        .m_axis_cq_tready (cq_tready),
        .s_axis_cc_tdata  (cc_tdata),
        .s_axis_cc_tuser  (cc_tuser),
        .s_axis_cc_tkeep  (cc_tkeep),
        .s_axis_cc_tlast  (cc_tlast),
        .s_axis_cc_tvalid (cc_tvalid),
        .s_axis_cc_tready (cc_tready),
        .reg_wr_valid     (reg_wr_valid),
        .reg_wr_idx       (reg_wr_idx),
        .reg_wr_data      (reg_wr_data),
        .req_cnt          (req_cnt)
    );

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_desc(input logic [63:0] addr, input logic [10:0] dw,
                                             input logic [3:0] typ, input logic [15:0] rid,
                                             input logic [7:0] tag, input logic [2:0] tc,
                                             input logic [2:0] attr);
        logic [127:0] d;
        d = '0;
        d[63:0]    = {addr[63:2], 2'b00};
        d[74:64]   = dw;
        d[78:75]   = typ;
        d[95:80]   = rid;
        d[103:96]  = tag;
        d[123:121] = tc;
        d[126:124] = attr;
        return d;
    endfunction

    function automatic logic [127:0] cc_exp(input logic [63:0] addr, input logic [15:0] rid,
                                            input logic [7:0] tag, input logic [2:0] tc,
                                            input logic [2:0] attr, input logic [31:0] data,
                                            input logic ur);
        logic [127:0] c;
        c = '0;
        c[6:0] = {addr[6:2], 2'b00};
        if (ur) begin
            c[45:43] = 3'b001;
        end else begin
            c[28:16]  = 13'd4;
            c[42:32]  = 11'd1;
            c[127:96] = data;
        end
        c[63:48] = rid;
        c[71:64] = tag;
        c[91:89] = tc;
        c[94:92] = attr;
        return c;
    endfunction

    // Single-dword MemRd with CC ready held high; starts and ends at a negedge.
    task automatic do_read(input string name, input logic [63:0] addr, input logic [7:0] tag,
                           input logic [15:0] rid, input logic [2:0] tc, input logic [2:0] attr,
                           input logic [31:0] exp_data, input logic exp_ur);
        cq_tdata  = mk_desc(addr, 11'd1, 4'b0000, rid, tag, tc, attr);
        cq_tuser  = '0;
        cq_tuser[3:0] = 4'hF;
        cq_tlast  = 1'b1;
        cq_tvalid = 1'b1;
        @(negedge clk);
        cq_tvalid = 1'b0;
        cq_tlast  = 1'b0;
        check({name, "_cpl_tready"}, cq_tready, 0);
        check({name, "_early_valid"}, cc_tvalid, 0);
        @(negedge clk);
        check({name, "_valid"}, cc_tvalid, 1);
        check({name, "_tdata"}, cc_tdata, cc_exp(addr, rid, tag, tc, attr, exp_data, exp_ur));
        check({name, "_tkeep"}, cc_tkeep, exp_ur ? 4'h7 : 4'hF);
        check({name, "_tlast"}, cc_tlast, 1);
        check({name, "_tuser"}, cc_tuser, 0);
        @(negedge clk);
        check({name, "_done_valid"}, cc_tvalid, 0);
        check({name, "_done_tready"}, cq_tready, 1);
    endtask

    // MemWr with nbeats data beats; starts and ends at a negedge.
    task automatic do_wr(input string name, input logic [63:0] addr, input logic [10:0] dw,
                         input logic [3:0] be, input logic [31:0] data, input int nbeats,
                         input logic exp_strobe, input logic [5:0] exp_idx,
                         input logic [31:0] exp_data);
        cq_tdata  = mk_desc(addr, dw, 4'b0001, 16'h0000, 8'h00, 3'd0, 3'd0);
        cq_tuser  = '0;
        cq_tuser[3:0] = be;
        cq_tlast  = 1'b0;
        cq_tvalid = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            cq_tdata = {96'd0, data + 32'(i)};
            cq_tlast = (i == nbeats - 1);
        end
        @(negedge clk);
        cq_tvalid = 1'b0;
        cq_tlast  = 1'b0;
        check({name, "_strobe"}, reg_wr_valid, exp_strobe);
        if (exp_strobe) begin
            check({name, "_idx"}, reg_wr_idx, exp_idx);
            check({name, "_data"}, reg_wr_data, exp_data);
        end
        check({name, "_no_cc"}, cc_tvalid, 0);
        @(negedge clk);
        check({name, "_strobe_off"}, reg_wr_valid, 0);
    endtask

    initial begin
        user_reset  = 1'b1;
        user_lnk_up = 1'b1;
        cq_tdata    = '0;
        cq_tuser    = '0;
        cq_tkeep    = 4'hF;
        cq_tlast    = 1'b0;
        cq_tvalid   = 1'b0;
        cc_tready   = 4'hF;
        repeat (3) @(negedge clk);
        user_reset = 1'b0;

        // Reset state
        check("rst_tready", cq_tready, 1);
        check("rst_cc_valid", cc_tvalid, 0);
        check("rst_req_cnt", req_cnt, 0);
        check("rst_wr_valid", reg_wr_valid, 0);

        // Full-dword write, then read it back with tag/requester ID
        do_wr("wr_full", 64'h08, 11'd1, 4'b1111, 32'hDEADBEEF, 1, 1'b1, 6'd2, 32'hDEADBEEF);
        check("cnt_after_wr", req_cnt, 1);
        do_read("rd_full", 64'h08, 8'h5A, 16'h0100, 3'd2, 3'd1, 32'hDEADBEEF, 1'b0);
        check("cnt_after_rd", req_cnt, 2);

        // Byte-enable merge, then read-after-write
        do_wr("wr_be", 64'h08, 11'd1, 4'b0010, 32'h00001200, 1, 1'b1, 6'd2, 32'hDEAD12EF);
        do_read("rd_be", 64'h08, 8'h21, 16'h0ABC, 3'd0, 3'd0, 32'hDEAD12EF, 1'b0);

        // Different index, partial byte enables
        do_wr("wr_idx7", 64'h1C, 11'd1, 4'b1001, 32'hA1B2C3D4, 1, 1'b1, 6'd7, 32'hA10000D4);
        do_read("rd_idx7", 64'h1C, 8'hFF, 16'hFFFF, 3'd7, 3'd7, 32'hA10000D4, 1'b0);

        // Drained writes: dword count 2 and out-of-range (would alias index 0)
        do_wr("wr_dw2", 64'h0C, 11'd2, 4'b1111, 32'h11111111, 2, 1'b0, 6'd0, 32'd0);
        do_read("rd_dw2", 64'h0C, 8'h01, 16'h0001, 3'd0, 3'd0, 32'h0, 1'b0);
        do_wr("wr_oor", 64'h40, 11'd1, 4'b1111, 32'h22222222, 1, 1'b0, 6'd0, 32'd0);
        do_read("rd_oor_alias", 64'h00, 8'h02, 16'h0002, 3'd0, 3'd0, 32'h0, 1'b0);

        // CC backpressure: beat held stable for 5 cycles
        cc_tready = 4'h0;
        cq_tdata  = mk_desc(64'h08, 11'd1, 4'b0000, 16'h1234, 8'h11, 3'd1, 3'd2);
        cq_tuser  = '0;
        cq_tuser[3:0] = 4'hF;
        cq_tlast  = 1'b1;
        cq_tvalid = 1'b1;
        @(negedge clk);
        cq_tvalid = 1'b0;
        cq_tlast  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", cc_tvalid, 1);
            check("stall_tdata", cc_tdata, cc_exp(64'h08, 16'h1234, 8'h11, 3'd1, 3'd2, 32'hDEAD12EF, 1'b0));
            check("stall_tready", cq_tready, 0);
        end
        cc_tready = 4'b0100;
        @(negedge clk);
        check("stall_release", cc_tvalid, 0);
        check("stall_idle_tready", cq_tready, 1);
        cc_tready = 4'hF;

        // Out-of-range MemRd at 0x100
`ifdef BAR_COMPLETER_UR_EN
        do_read("rd_ur", 64'h100, 8'h33, 16'h0200, 3'd0, 3'd0, 32'h0, 1'b1);
`else
        cq_tdata  = mk_desc(64'h100, 11'd1, 4'b0000, 16'h0200, 8'h33, 3'd0, 3'd0);
        cq_tlast  = 1'b1;
        cq_tvalid = 1'b1;
        @(negedge clk);
        cq_tvalid = 1'b0;
        cq_tlast  = 1'b0;
        check("rd_oor_tready", cq_tready, 1);
        @(negedge clk);
        check("rd_oor_no_cc", cc_tvalid, 0);
        @(negedge clk);
        check("rd_oor_no_cc2", cc_tvalid, 0);
`endif

        // Link drop while waiting on CC ready
        cc_tready = 4'h0;
        cq_tdata  = mk_desc(64'h08, 11'd1, 4'b0000, 16'h4321, 8'h44, 3'd0, 3'd0);
        cq_tlast  = 1'b1;
        cq_tvalid = 1'b1;
        @(negedge clk);
        cq_tvalid = 1'b0;
        cq_tlast  = 1'b0;
        @(negedge clk);
        check("lnk_pre_valid", cc_tvalid, 1);
        user_lnk_up = 1'b0;
        @(negedge clk);
        check("lnk_cc_valid", cc_tvalid, 0);
        check("lnk_req_cnt", req_cnt, 0);
        check("lnk_tready", cq_tready, 1);
        user_lnk_up = 1'b1;
        cc_tready   = 4'hF;
        @(negedge clk);
        check("lnk_no_late_cc", cc_tvalid, 0);
        do_read("rd_after_lnk", 64'h08, 8'h55, 16'h0003, 3'd0, 3'd0, 32'h0, 1'b0);

        // req_cnt wrap using back-to-back posted messages
        user_reset = 1'b1;
        @(negedge clk);
        user_reset = 1'b0;
        check("wrap_start", req_cnt, 0);
        cq_tdata  = mk_desc(64'h0, 11'd0, 4'b1100, 16'h0, 8'h0, 3'd0, 3'd0);
        cq_tlast  = 1'b1;
        cq_tvalid = 1'b1;
        repeat (65535) @(negedge clk);
        check("wrap_ffff", req_cnt, 16'hFFFF);
        @(negedge clk);
        cq_tvalid = 1'b0;
        cq_tlast  = 1'b0;
        check("wrap_zero", req_cnt, 16'h0000);
        check("wrap_no_cc", cc_tvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bar_completer.md
BAR_COMPLETER -- requirements
Module: bar_completer

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 128, the AXIS data width.
REQ-002 SHALL have parameter AXI4_CQ_TUSER_WIDTH, default 88, the CQ tuser width.
REQ-003 SHALL have parameter AXI4_CC_TUSER_WIDTH, default 33, the CC tuser width.
REQ-004 SHALL have parameter KEEP_WIDTH, default C_DATA_WIDTH/32, the dword keep width.
REQ-005 SHALL have parameter REG_COUNT, default 16, the number of 32-bit registers (power of two, at most 64).
REQ-006 SHALL have port user_clk, input, 1: the only clock. Single clock domain; reset is synchronous and active-high.
REQ-007 SHALL have port user_reset, input, 1: synchronous active-high reset.
REQ-008 SHALL have port user_lnk_up, input, 1: link up; low acts as reset.
REQ-009 SHALL have CQ inputs m_axis_cq_tdata, m_axis_cq_tuser, m_axis_cq_tkeep, m_axis_cq_tlast and m_axis_cq_tvalid, each at its parameter width, carrying host requests.
REQ-010 SHALL have port m_axis_cq_tready, output, 1: CQ accept.
REQ-011 SHALL have CC outputs s_axis_cc_tdata, s_axis_cc_tuser, s_axis_cc_tkeep, s_axis_cc_tlast and s_axis_cc_tvalid, each at its parameter width, carrying completions.
REQ-012 SHALL have port s_axis_cc_tready, input, 4: CC ready; any bit set means ready.
REQ-013 SHALL have reg_wr_valid (output, 1), reg_wr_idx (output, 6) and reg_wr_data (output, 32), together a one-cycle write-notify strobe.
REQ-014 SHALL have port req_cnt, output, 16: count of accepted requests (debug).

Function
REQ-015 SHALL decode the CQ descriptor as follows: address [63:2]; dword count [74:64]; req type [78:75] (MemRd 0000, MemWr 0001); requester ID [95:80]; tag [103:96]; TC [123:121]; attr [126:124]; first BE m_axis_cq_tuser[3:0].
REQ-016 SHALL select the register index as addr[7:2] modulo REG_COUNT, and SHALL treat addr[11:2] >= REG_COUNT as out of range.
REQ-017 SHALL implement FSM states ST_IDLE, ST_WR_DATA, ST_CPL and ST_CPL_WAIT.
REQ-018 ST_IDLE SHALL behave as follows: cq_tready=1. On a descriptor beat (tvalid), capture the header; go to ST_WR_DATA for MemWr without tlast, ST_CPL for MemRd, and stay in ST_IDLE otherwise.
REQ-019 ST_WR_DATA SHALL behave as follows: cq_tready=1. On the data beat, if dword count==1 and the address is in range, write data[31:0] under first BE. Continue draining beats until tlast, then return to ST_IDLE.
REQ-020 A MemWr with dword count!=1 or an out-of-range address SHALL be drained with no register update and no strobe.
REQ-021 ST_CPL SHALL deassert cq_tready and drive the CC beat with: lower addr {addr[6:2],2'b00} in [6:0]; byte count 4 in [28:16]; dword count 1 in [42:32]; status 000 in [45:43]; requester ID in [63:48]; tag in [71:64]; TC in [91:89]; attr in [94:92]; register data in [127:96]; tkeep 1111; tlast 1; tuser 0.
REQ-022 ST_CPL SHALL go to ST_CPL_WAIT when the CC ready is low, otherwise to ST_IDLE.
REQ-023 ST_CPL_WAIT SHALL hold the CC beat stable with tvalid=1 until ready, then go to ST_IDLE.
REQ-024 The completion SHALL appear registered, 2 cycles after the MemRd descriptor beat when CC ready is high.
REQ-025 SHALL pulse reg_wr_valid for 1 cycle, registered, on the same edge as the register update, carrying the post-merge value.
REQ-026 SHALL increment req_cnt per descriptor accepted and SHALL wrap from 16'hFFFF to 0.
REQ-027 SHALL give a read that follows a write to the same index the new value, with no hazard.
REQ-028 SHALL treat a CQ beat with tvalid while cq_tready=0 as not consumed.

Reset
REQ-029 SHALL, when user_reset=1 or user_lnk_up=0, set the FSM to ST_IDLE, all registers, req_cnt, the CC outputs and reg_wr_valid to 0, and cq_tready to 1 in the following cycle.
REQ-030 SHALL abandon a reset applied mid-completion or mid-drain, with no CC beat emitted afterwards.

Configuration
REQ-031 With BAR_COMPLETER_UR_EN defined, a MemRd that is out of range or has dword count!=1, and any other non-posted type, SHALL get a CC beat with status 001 (UR), dword count 0, byte count 0, data 0, and tkeep 0111.
REQ-032 Without BAR_COMPLETER_UR_EN, such requests SHALL be drained silently in ST_IDLE/ST_WR_DATA with no CC beat.

Structure
REQ-033 SHALL place the req-type codes, the CC status codes, the FSM state encoding, and the CQ/CC descriptor field offsets in the shared package nvme_pcie_pkg.
REQ-034 SHALL place the register file with byte-enable write and registered read in the sub-module bar_reg_file.

Verification
REQ-035 SHALL cover this scenario: MemWr addr 0x08, DW=1, BE=1111, data 0xDEADBEEF -> reg_wr_valid pulse, idx 2, data 0xDEADBEEF, no CC beat.
REQ-036 SHALL cover this scenario: MemRd addr 0x08, tag 0x5A, req ID 0x0100 -> CC beat 2 cycles later with tag 0x5A, [63:48]=0x0100, status 000, [127:96]=0xDEADBEEF.
REQ-037 SHALL cover this scenario: MemWr BE=0010, data 0x00001200, to a register holding 0xDEADBEEF -> register reads 0xDEAD12EF.
REQ-038 SHALL cover this scenario: MemRd with CC ready low for 5 cycles -> CC beat held stable for 5 cycles, cq_tready=0 throughout, released on ready.
REQ-039 SHALL cover this scenario: MemRd addr 0x100 with REG_COUNT=16 -> UR beat (status 001) with the macro defined, no beat without it.
REQ-040 SHALL cover this scenario: user_lnk_up dropped during ST_CPL_WAIT -> cc_tvalid=0 the next cycle, registers 0, req_cnt 0.
